wr_arbiter: RTL and testbench
=============================

WR_ARBITER -- requirements
Module: wr_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles in RESP waiting for the B handshake before the grant is forcibly released; legal range 2..255.
REQ-002 Parameter CNT_W, default 8: width of the response timeout counter; SHALL satisfy 2^CNT_W > TIMEOUT.
REQ-003 Clock and reset are fixed: one clock; reset is synchronous and active-high.
REQ-004 Port ACLK, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port ARESET, input, 1: synchronous, active-high reset.
REQ-006 Port m1_AWVALID, input, 1: master 1 requests a write transaction.
REQ-007 Port m2_AWVALID, input, 1: master 2 requests a write transaction.
REQ-008 Port AWVALID / AWREADY, input, 1 each: AW handshake on the shared (already muxed) channel.
REQ-009 Port WVALID / WREADY / WLAST, input, 1 each: W handshake and last-beat flag on the shared channel.
REQ-010 Port BVALID / BREADY, input, 1 each: B handshake on the shared channel.
REQ-011 Port mas_sel, output, 2: registered grant; 2'b01 = master 1, 2'b10 = master 2, 2'b00 = none; 2'b11 is never driven.
REQ-012 Port busy, output, 1: high whenever the state is not IDLE.
REQ-013 Port timeout_err, output, 1: one-cycle pulse on a forced release.

Function
REQ-014 The block SHALL implement states IDLE, XFER and RESP, plus a 1-bit round-robin pointer prio (0 = master 1 first).
REQ-015 In IDLE with exactly one mXAWVALID high, the block SHALL grant that master: mas_sel is updated at the next edge and the state moves to XFER.
REQ-016 In IDLE with both requests high, the block SHALL grant master 1 if prio=0 and master 2 if prio=1.
REQ-017 In IDLE with no request, the block SHALL hold mas_sel=2'b00 and remain in IDLE.
REQ-018 Latency from a request sampled in IDLE to a valid mas_sel SHALL be exactly 1 cycle.
REQ-019 XFER SHALL track two sticky flags, aw_done and w_done, both cleared on entry to XFER.
- aw_done sets on AWVALID&AWREADY.
- w_done sets on WVALID&WREADY&WLAST.
REQ-020 AW and last-W handshakes SHALL be accepted in the same cycle or in any order.
REQ-021 The state SHALL move XFER->RESP at the edge where both flags are set or are being set in that cycle.
REQ-022 W beats without WLAST SHALL not affect the state machine.
REQ-023 In RESP, the counter SHALL start from 0 and increment by 1 per cycle without a B handshake.
REQ-024 A BVALID&BREADY handshake in RESP SHALL cause:
- state -> IDLE;
- mas_sel -> 2'b00 at the same edge;
- prio set to point at the master that did not just complete.
REQ-025 If the counter reaches TIMEOUT-1 without a B handshake, the next edge SHALL cause:
- state -> IDLE;
- mas_sel -> 2'b00;
- prio flips as in REQ-024;
- timeout_err high for exactly that one following cycle.
REQ-026 If the B handshake and the timeout condition coincide, the handshake SHALL win and timeout_err stays 0.
REQ-027 mas_sel SHALL remain constant throughout XFER and RESP, regardless of the mXAWVALID inputs.
REQ-028 There SHALL be at least one IDLE cycle with mas_sel=2'b00 between consecutive grants.
REQ-029 The counter SHALL saturate rather than wrap and SHALL be cleared in IDLE.
REQ-030 The handshake inputs (AW, W, B) SHALL be ignored while in IDLE.

Reset
REQ-031 ARESET high at an edge SHALL force, from any state and mid-transaction:
- state=IDLE, mas_sel=2'b00, busy=0, timeout_err=0;
- prio=0, counter=0, aw_done=w_done=0.
REQ-032 The block SHALL ignore all requests on a cycle where ARESET is sampled high.

Verification
REQ-033 Single master: m1_AWVALID=1 in IDLE -> mas_sel=2'b01 next cycle; AW, then a 4-beat W with WLAST, then B -> mas_sel=2'b00 and prio=1.
REQ-034 Contention: both requests held high -> grants alternate 01, 00, 10, 00, 01 across three complete transactions.
REQ-035 Concurrent AW and last-W in the same cycle -> RESP entered at the next edge; W handshake before AW also accepted.
REQ-036 No BVALID with TIMEOUT=16 -> mas_sel drops 16 cycles after RESP entry, timeout_err=1 for one cycle, prio flips.
REQ-037 ARESET asserted during XFER with master 2 granted -> mas_sel=2'b00, busy=0 next cycle; a following dual request grants master 1.
REQ-038 BVALID&BREADY on the timeout cycle -> normal release, timeout_err stays 0.

Source files
------------

// File: rtl/wr_arbiter.sv
// Write-channel arbiter for two masters sharing one AW/W/B path.
// Grants one master at a time. The grant is held until the B response
// completes or the response wait times out. Contention is broken by a
// 1-bit round-robin pointer.
module wr_arbiter #(
    parameter int TIMEOUT = 16,   // max RESP cycles before forced release (2..255)
    parameter int CNT_W   = 8     // 2**CNT_W must exceed TIMEOUT
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       m1_AWVALID,
    input  logic       m2_AWVALID,
    input  logic       AWVALID,
    input  logic       AWREADY,
    input  logic       WVALID,
    input  logic       WREADY,
    input  logic       WLAST,
    input  logic       BVALID,
    input  logic       BREADY,
    output logic [1:0] mas_sel,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    logic [1:0]       r_mas_sel;
    logic             r_prio;        // 0: master 1 wins a tie, 1: master 2 wins
    logic [CNT_W-1:0] r_cnt;
    logic             r_aw_done;
    logic             r_w_done;
    logic             r_timeout_err;

    logic w_aw_hs;
    logic w_wlast_hs;
    logic w_b_hs;
    logic w_aw_done_next;
    logic w_w_done_next;
    logic w_timeout;

    // Handshake decode and "done or completing this cycle" flags
    always_comb begin
        w_aw_hs        = AWVALID & AWREADY;
        w_wlast_hs     = WVALID & WREADY & WLAST;
        w_b_hs         = BVALID & BREADY;
        w_aw_done_next = r_aw_done | w_aw_hs;
        w_w_done_next  = r_w_done | w_wlast_hs;
        w_timeout      = (r_cnt >= CNT_LAST);
    end

    // Arbitration FSM with registered grant, round-robin pointer and timeout
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state       <= IDLE;
            r_mas_sel     <= 2'b00;
            r_prio        <= 1'b0;
            r_cnt         <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Handshake inputs are ignored here; flags start clean for XFER
                    r_cnt     <= '0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    if (m1_AWVALID && (!m2_AWVALID || !r_prio)) begin
                        r_mas_sel <= 2'b01;
                        r_state   <= XFER;
                    end else if (m2_AWVALID) begin
                        r_mas_sel <= 2'b10;
                        r_state   <= XFER;
                    end else begin
                        r_mas_sel <= 2'b00;
                    end
                end
                XFER: begin
                    r_aw_done <= w_aw_done_next;
                    r_w_done  <= w_w_done_next;
                    if (w_aw_done_next && w_w_done_next) begin
                        r_state <= RESP;
                        r_cnt   <= '0;
                    end
                end
                RESP: begin
                    // A B handshake takes precedence over a coinciding timeout
                    if (w_b_hs || w_timeout) begin
                        r_state       <= IDLE;
                        r_mas_sel     <= 2'b00;
                        r_prio        <= (r_mas_sel == 2'b01);
                        r_timeout_err <= !w_b_hs;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mas_sel <= 2'b00;
                end
            endcase
        end
    end

    assign mas_sel     = r_mas_sel;
    assign busy        = (r_state != IDLE);
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_wr_arbiter.sv
// Directed bench for wr_arbiter: single master, contention, handshake
// ordering, timeout, timeout/B coincidence and mid-transfer reset.
module tb_wr_arbiter;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       m1_AWVALID, m2_AWVALID;
    logic       AWVALID, AWREADY;
    logic       WVALID, WREADY, WLAST;
    logic       BVALID, BREADY;
    logic [1:0] mas_sel;
    logic       busy;
    logic       timeout_err;

    int vectors = 0;
    int miscompares = 0;

    wr_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .m1_AWVALID  (m1_AWVALID),
        .m2_AWVALID  (m2_AWVALID),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .WLAST       (WLAST),
        .BVALID      (BVALID),
        .BREADY      (BREADY),
        .mas_sel     (mas_sel),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 ACLK = ~ACLK;

    // Advance one rising edge, then settle before sampling or driving
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_sel,
                           input logic e_busy, input logic e_terr);
        chk({tag, ".mas_sel"}, mas_sel, e_sel);
        chk({tag, ".busy"}, {1'b0, busy}, {1'b0, e_busy});
        chk({tag, ".timeout_err"}, {1'b0, timeout_err}, {1'b0, e_terr});
        $display("step %s: mas_sel=%b busy=%b timeout_err=%b", tag, mas_sel, busy, timeout_err);
    endtask

    initial begin
        ARESET = 1'b1;
        m1_AWVALID = 0; m2_AWVALID = 0;
        AWVALID = 0; AWREADY = 0;
        WVALID = 0; WREADY = 0; WLAST = 0;
        BVALID = 0; BREADY = 0;

        // Reset, with requests present: they must be ignored
        m1_AWVALID = 1; m2_AWVALID = 1;
        step(); step();
        chk_all("reset", 2'b00, 0, 0);
        m1_AWVALID = 0; m2_AWVALID = 0;
        ARESET = 0;
        step();
        chk_all("idle_noreq", 2'b00, 0, 0);

        // Single master 1: AW, then 4 W beats, then B
        m1_AWVALID = 1;
        step();
        chk_all("t1_grant", 2'b01, 1, 0);
        m1_AWVALID = 0;
        AWVALID = 1; AWREADY = 1;
        step();
        chk_all("t1_aw", 2'b01, 1, 0);
        AWVALID = 0; AWREADY = 0;
        WVALID = 1; WREADY = 1;
        for (int i = 0; i < 4; i++) begin
            WLAST = (i == 3);
            step();
            chk_all($sformatf("t1_w%0d", i), 2'b01, 1, 0);
        end
        WVALID = 0; WREADY = 0; WLAST = 0;
        // BVALID without BREADY is not a handshake
        BVALID = 1;
        step();
        chk_all("t1_bwait", 2'b01, 1, 0);
        BREADY = 1;
        step();
        chk_all("t1_release", 2'b00, 0, 0);
        BVALID = 0; BREADY = 0;

        // Contention: prio now points at master 2
        m1_AWVALID = 1; m2_AWVALID = 1;
        step();
        chk_all("t2_grant", 2'b10, 1, 0);
        // AW and last W in the same cycle -> RESP next edge
        AWVALID = 1; AWREADY = 1; WVALID = 1; WREADY = 1; WLAST = 1;
        step();
        AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; WLAST = 0;
        chk_all("t2_resp", 2'b10, 1, 0);
        BVALID = 1; BREADY = 1;
        step();
        chk_all("t2_release", 2'b00, 0, 0);
        BVALID = 0; BREADY = 0;
        step();
        chk_all("t3_grant", 2'b01, 1, 0);
        // Last W before AW
        WVALID = 1; WREADY = 1; WLAST = 1;
        step();
        WVALID = 0; WREADY = 0; WLAST = 0;
        chk_all("t3_w_first", 2'b01, 1, 0);
        AWVALID = 1; AWREADY = 1;
        step();
        AWVALID = 0; AWREADY = 0;
        chk_all("t3_aw_after", 2'b01, 1, 0);
        BVALID = 1; BREADY = 1;
        step();
        chk_all("t3_release", 2'b00, 0, 0);
        BVALID = 0; BREADY = 0;

        // Timeout with master 2 granted; both requests stay high
        step();
        chk_all("t4_grant", 2'b10, 1, 0);
        AWVALID = 1; AWREADY = 1; WVALID = 1; WREADY = 1; WLAST = 1;
        step();
        AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; WLAST = 0;
        for (int i = 1; i < 16; i++) begin
            step();
            chk_all($sformatf("t4_wait%0d", i), 2'b10, 1, 0);
        end
        step();
        chk_all("t4_timeout", 2'b00, 0, 1);
        step();
        chk_all("t5_grant", 2'b01, 1, 0);

        // B handshake coinciding with the timeout edge, master 1 granted
        AWVALID = 1; AWREADY = 1; WVALID = 1; WREADY = 1; WLAST = 1;
        step();
        AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; WLAST = 0;
        for (int i = 1; i < 16; i++) begin
            step();
            if (i == 15) chk_all("t5_wait15", 2'b01, 1, 0);
        end
        BVALID = 1; BREADY = 1;
        step();
        chk_all("t5_b_wins", 2'b00, 0, 0);
        BVALID = 0; BREADY = 0;
        step();
        chk_all("t6_grant", 2'b10, 1, 0);

        // Reset during XFER with master 2 granted
        ARESET = 1;
        step();
        chk_all("t6_reset", 2'b00, 0, 0);
        ARESET = 0;
        step();
        chk_all("t7_grant_after_reset", 2'b01, 1, 0);
        m1_AWVALID = 0; m2_AWVALID = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute bound so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
